intt_stream: RTL and testbench
==============================

Name: intt_stream

Overview:
- Inverse number-theoretic transform. Companion to the forward NTT block: takes the transformed vector back to the coefficient domain, so round-trip tests of the forward NTT close in hardware.
- Coefficients stream in serially over a valid/ready handshake and are buffered.
- Computes y[j] = N_INV * sum_i x[i]*W_INV^(i*j) mod MOD with one sequential MAC. Twiddles come from running products, so no twiddle table is needed.
- Results stream out over valid/ready.

Parameters:
- N, 64, transform length; power of two, >= 2.
- W, 64, coefficient width in bits.
- MOD, 64'hFFFFFFFF00000001, prime modulus, < 2^W.
- W_INV, 64'h0, inverse of the primitive N-th root of unity mod MOD; set per instance.
- N_INV, 64'h0, N^-1 mod MOD; set per instance.

Ports:
- clk, input, 1, clock; all state changes on posedge.
- rst, input, 1, reset, asynchronous, active-low.
- in_valid, input, 1, in_data holds a coefficient.
- in_ready, output, 1, block accepts a coefficient this cycle.
- in_data, input, W, input coefficient; x[0] first.
- out_valid, output, 1, out_data holds a result.
- out_ready, input, 1, consumer accepts the result.
- out_data, output, W, result coefficient; y[0] first.
- out_last, output, 1, high with y[N-1].
- busy, output, 1, high in any state other than LOAD.

Behaviour:
- rst low (async) resets:
  - state=LOAD, all counters=0, acc=0, tw=1, step=1.
  - in_ready=1, out_valid=0, out_last=0, out_data=0, busy=0.
  - Buffer contents are don't-care.
- modmul(a,b) = (a*b) mod MOD on a 2W-bit product; single cycle, combinational.
- Captured inputs are reduced mod MOD on capture. All stored values stay < MOD.
- States:
  - LOAD
    - in_ready=1.
    - On in_valid&&in_ready: xbuf[icnt]=in_data mod MOD, icnt++.
    - After the N-th accept: go to MAC with i=0, j=0, acc=0, tw=1, step=1; in_ready drops the next cycle.
  - MAC (one cycle per i)
    - acc = (acc + modmul(xbuf[i], tw)) mod MOD.
    - tw = modmul(tw, step). tw holds W_INV^(i*j) during the cycle.
    - i++. After i=N-1, go to FIN.
  - FIN (one cycle)
    - ybuf[j] = modmul(acc, N_INV).
    - step = modmul(step, W_INV).
    - acc=0, tw=1, i=0.
    - If j==N-1, go to DRAIN; else j++ and return to MAC.
  - DRAIN
    - out_valid=1, out_data=ybuf[ocnt], out_last=(ocnt==N-1).
    - On out_valid&&out_ready: ocnt++.
    - On the handshake with ocnt==N-1: go to LOAD; out_valid=0 the next cycle; icnt=ocnt=0.
- Latency:
  - Compute from the last input accept to first out_valid is N*(N+1)+1 cycles (MAC/FIN sequence plus DRAIN entry). For N=4 this is 21 cycles.
  - Throughput is one block per N + N*(N+1) + N cycles minimum.
- Handshakes:
  - in_ready is 0 outside LOAD. in_data is ignored when in_valid&&!in_ready.
  - out_data and out_last hold stable while out_valid&&!out_ready. Stalls of any length are allowed.
  - in_ready and out_valid are never high together. No overlap of blocks.
- Boundaries:
  - Gaps in in_valid during LOAD only extend LOAD.
  - in_valid held high across the LOAD exit must not capture an (N+1)-th word.
  - Reset during MAC, FIN or DRAIN aborts: out_valid drops immediately (async), and the next block restarts from x[0].
  - Counters are log2(N) bits and compare explicitly to N-1; no reliance on wrap.
  - acc addition is done in W+1 bits before the conditional subtract of MOD.

Test Plan:
- Use N=4, MOD=17, W=8, W_INV=13, N_INV=13 (forward root 4) unless noted.
- Delta input x=[1,0,0,0], out_ready=1 -> y=[13,13,13,13]; out_last on the 4th word; first out_valid exactly 21 cycles after the 4th accept.
- Constant x=[1,1,1,1] -> y=[1,0,0,0]. Shifted delta x=[0,1,0,0] -> y=[13,16,4,1].
- Unreduced input x=[18,0,0,0] (18 mod 17 = 1) -> y=[13,13,13,13]; in_valid toggled 1/0 during LOAD still yields the same result.
- Backpressure: out_ready low for 5 cycles at ocnt=2 -> out_data holds y[2] stable; no word lost or duplicated; in_ready stays 0 until the final handshake.
- Reset asserted mid-MAC (row 2) -> outputs return to reset values asynchronously. A fresh block x=[1,1,1,1] then yields [1,0,0,0].
- Round trip at defaults (N=64, Goldilocks MOD with matching W_INV/N_INV): feed a random reduced vector through the forward NTT, then this block -> output equals the original vector; busy high from the last accept until the final output handshake.

Source files
------------

// File: rtl/intt_stream.sv
// Streaming inverse NTT: buffers N coefficients, runs one sequential MAC
// per output row with running-product twiddles, then drains the results.
module intt_stream #(
    parameter int unsigned    N     = 64,
    parameter int unsigned    W     = 64,
    parameter logic [W-1:0]   MOD   = 64'hFFFFFFFF00000001,
    parameter logic [W-1:0]   W_INV = 64'h0,
    parameter logic [W-1:0]   N_INV = 64'h0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         busy
);

    localparam int unsigned    LW   = $clog2(N);
    localparam logic [LW-1:0] LAST = LW'(N - 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_MAC,
        S_FIN,
        S_DRAIN
    } state_e;

    state_e state_q, state_d;

    logic [LW-1:0] icnt_q, icnt_d;
    logic [LW-1:0] i_q, i_d;
    logic [LW-1:0] j_q, j_d;
    logic [LW-1:0] ocnt_q, ocnt_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  tw_q, tw_d;
    logic [W-1:0]  step_q, step_d;

    logic [W-1:0]  xbuf_q [N];
    logic [W-1:0]  ybuf_q [N];

    logic          in_hs;
    logic          out_hs;
    logic [W-1:0]  in_word;
    logic [W-1:0]  mac_prod;
    logic [W:0]    acc_sum;
    logic [W-1:0]  acc_next;
    logic [W-1:0]  fin_word;

    function automatic logic [W-1:0] modmul(
        input logic [W-1:0] a,
        input logic [W-1:0] b
    );
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return W'(p % {{W{1'b0}}, MOD});
    endfunction

    assign in_ready  = (state_q == S_LOAD);
    assign out_valid = (state_q == S_DRAIN);
    assign busy      = (state_q != S_LOAD);
    assign out_data  = out_valid ? ybuf_q[ocnt_q] : '0;
    assign out_last  = out_valid && (ocnt_q == LAST);

    assign in_hs   = in_valid && in_ready;
    assign out_hs  = out_valid && out_ready;
    assign in_word = in_data % MOD;

    // One extra bit keeps the modular add exact before the single subtract.
    assign mac_prod = modmul(xbuf_q[i_q], tw_q);
    assign acc_sum  = {1'b0, acc_q} + {1'b0, mac_prod};
    assign acc_next = (acc_sum >= {1'b0, MOD}) ?
                      W'(acc_sum - {1'b0, MOD}) : acc_sum[W-1:0];
    assign fin_word = modmul(acc_q, N_INV);

    always_comb begin
        state_d = state_q;
        icnt_d  = icnt_q;
        i_d     = i_q;
        j_d     = j_q;
        ocnt_d  = ocnt_q;
        acc_d   = acc_q;
        tw_d    = tw_q;
        step_d  = step_q;
        unique case (state_q)
            S_LOAD: begin
                if (in_hs) begin
                    if (icnt_q == LAST) begin
                        state_d = S_MAC;
                        icnt_d  = '0;
                        i_d     = '0;
                        j_d     = '0;
                        acc_d   = '0;
                        tw_d    = W'(1);
                        step_d  = W'(1);
                    end else begin
                        icnt_d = icnt_q + LW'(1);
                    end
                end
            end
            S_MAC: begin
                acc_d = acc_next;
                tw_d  = modmul(tw_q, step_q);
                if (i_q == LAST) begin
                    i_d     = '0;
                    state_d = S_FIN;
                end else begin
                    i_d = i_q + LW'(1);
                end
            end
            S_FIN: begin
                // Row j+1 walks powers of W_INV^(j+1).
                step_d = modmul(step_q, W_INV);
                acc_d  = '0;
                tw_d   = W'(1);
                i_d    = '0;
                if (j_q == LAST) begin
                    j_d     = '0;
                    state_d = S_DRAIN;
                end else begin
                    j_d     = j_q + LW'(1);
                    state_d = S_MAC;
                end
            end
            S_DRAIN: begin
                if (out_hs) begin
                    if (ocnt_q == LAST) begin
                        state_d = S_LOAD;
                        ocnt_d  = '0;
                        icnt_d  = '0;
                    end else begin
                        ocnt_d = ocnt_q + LW'(1);
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_LOAD;
            icnt_q  <= '0;
            i_q     <= '0;
            j_q     <= '0;
            ocnt_q  <= '0;
            acc_q   <= '0;
            tw_q    <= W'(1);
            step_q  <= W'(1);
        end else begin
            state_q <= state_d;
            icnt_q  <= icnt_d;
            i_q     <= i_d;
            j_q     <= j_d;
            ocnt_q  <= ocnt_d;
            acc_q   <= acc_d;
            tw_q    <= tw_d;
            step_q  <= step_d;
        end
    end

    // Sample and result buffers carry no reset; contents are rewritten per block.
    always_ff @(posedge clk) begin
        if (in_hs) begin
            xbuf_q[icnt_q] <= in_word;
        end
        if (state_q == S_FIN) begin
            ybuf_q[j_q] <= fin_word;
        end
    end

endmodule

// File: tb/tb_intt_stream.sv
// Directed bench for intt_stream: N=4 mod-17 vectors plus a
// Goldilocks N=64 round trip against a forward NTT model.
`timescale 1ns/1ps
module tb_intt_stream;

    localparam logic [63:0] P    = 64'hFFFFFFFF00000001;
    localparam logic [63:0] WFWD = 64'd8;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [7:0] in_data, out_data;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic        b_out_last, b_busy;
    logic [63:0] b_in_data, b_out_data;

    logic [63:0] rx [64];
    logic [63:0] rX [64];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    intt_stream #(
        .N(4), .W(8), .MOD(8'd17), .W_INV(8'd13), .N_INV(8'd13)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy)
    );

    intt_stream #(
        .N(64), .W(64), .MOD(P),
        .W_INV(64'hDFFFFFFF20000001), .N_INV(64'hFBFFFFFF04000001)
    ) dut64 (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_last(b_out_last), .busy(b_busy)
    );

    function automatic logic [63:0] mm(input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        p = {64'd0, a} * {64'd0, b};
        return 64'(p % {64'd0, P});
    endfunction

    task automatic send_block(input logic [31:0] xs, input bit gaps, input bit hold);
        int t;
        for (int k = 0; k < 4; k++) begin
            if (gaps) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_data  = 8'hEE;
                @(negedge clk);
            end else begin
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = xs[k*8 +: 8];
            t = 0;
            while (!in_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                errors++;
                checks++;
                $display("FAIL send_wait: in_ready=%0d want 1", in_ready);
            end
            @(posedge clk);
        end
        @(negedge clk);
        if (hold) begin
            in_valid = 1'b1;
            in_data  = 8'hAA;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_in_ready: got %0d want 0", in_ready);
            end
            repeat (3) @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic recv_block(input logic [31:0] ys, input int stall_at,
                              input int stall_len, input string tag);
        int t;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            t = 0;
            while (!out_valid && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (!out_valid) begin
                errors++;
                checks++;
                $display("FAIL %s_timeout: word %0d never valid", tag, k);
                return;
            end
            if (k == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    checks++;
                    if (out_valid !== 1'b1 || out_data !== ys[k*8 +: 8] ||
                        in_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL %s_stall: v=%0d d=%0d rdy=%0d want 1 %0d 0",
                                 tag, out_valid, out_data, in_ready, ys[k*8 +: 8]);
                    end
                end
                out_ready = 1'b1;
            end
            checks++;
            if (out_data !== ys[k*8 +: 8]) begin
                errors++;
                $display("FAIL %s_y%0d: got %0d want %0d", tag, k, out_data, ys[k*8 +: 8]);
            end
            checks++;
            if (out_last !== (k == 3)) begin
                errors++;
                $display("FAIL %s_last%0d: got %0d want %0d", tag, k, out_last, (k == 3));
            end
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_end: v=%0d rdy=%0d busy=%0d want 0 1 0",
                     tag, out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        out_ready = 1'b1;
        b_in_valid = 1'b0;
        b_in_data = 64'd0;
        b_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 ||
            out_data !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset: rdy=%0d v=%0d last=%0d d=%0d busy=%0d want 1 0 0 0 0",
                     in_ready, out_valid, out_last, out_data, busy);
        end
        checks++;
        if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset64: rdy=%0d v=%0d busy=%0d want 1 0 0",
                     b_in_ready, b_out_valid, b_busy);
        end
        rst = 1'b1;
    endtask

    task automatic test_delta();
        int c;
        logic busy_ok;
        send_block(32'h00000001, 1'b0, 1'b0);
        c = 1;
        busy_ok = 1'b1;
        while (!out_valid && c < 100) begin
            if (!busy || in_ready) busy_ok = 1'b0;
            @(negedge clk);
            c++;
        end
        checks++;
        if (c != 21) begin
            errors++;
            $display("FAIL latency: got %0d want 21", c);
        end
        checks++;
        if (!busy_ok) begin
            errors++;
            $display("FAIL compute_busy: got 0 want 1");
        end
        recv_block({8'd13, 8'd13, 8'd13, 8'd13}, -1, 0, "delta");
    endtask

    task automatic test_vectors();
        send_block(32'h01010101, 1'b0, 1'b0);
        recv_block(32'h00000001, -1, 0, "const");
        send_block(32'h00000100, 1'b0, 1'b1);
        recv_block({8'd1, 8'd4, 8'd16, 8'd13}, -1, 0, "shift");
    endtask

    task automatic test_unreduced_gaps();
        send_block(32'h00000012, 1'b1, 1'b0);
        recv_block({8'd13, 8'd13, 8'd13, 8'd13}, -1, 0, "unred");
    endtask

    task automatic test_backpressure();
        send_block(32'h00000100, 1'b0, 1'b0);
        recv_block({8'd1, 8'd4, 8'd16, 8'd13}, 2, 5, "bp");
    endtask

    task automatic test_abort();
        int t;
        send_block(32'h01010101, 1'b0, 1'b0);
        repeat (11) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_mac: rdy=%0d busy=%0d v=%0d want 1 0 0",
                     in_ready, busy, out_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        send_block(32'h00000001, 1'b0, 1'b0);
        out_ready = 1'b0;
        t = 0;
        while (!out_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'd0 || out_last !== 1'b0 ||
            in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_drain: v=%0d d=%0d last=%0d rdy=%0d want 0 0 0 1",
                     out_valid, out_data, out_last, in_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        send_block(32'h01010101, 1'b0, 1'b0);
        recv_block(32'h00000001, -1, 0, "restart");
    endtask

    task automatic test_round_trip();
        logic [63:0] acc, tw, wk;
        logic        busy_ok;
        int          got, t;
        for (int i = 0; i < 64; i++) begin
            rx[i] = {$urandom, $urandom} % P;
        end
        wk = 64'd1;
        for (int k = 0; k < 64; k++) begin
            acc = 64'd0;
            tw  = 64'd1;
            for (int i = 0; i < 64; i++) begin
                acc = 64'(({64'd0, acc} + {64'd0, mm(rx[i], tw)}) % {64'd0, P});
                tw  = mm(tw, wk);
            end
            rX[k] = acc;
            wk = mm(wk, WFWD);
        end
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            b_in_valid = 1'b1;
            b_in_data  = rX[k];
            @(posedge clk);
        end
        @(negedge clk);
        b_in_valid = 1'b0;
        b_out_ready = 1'b1;
        busy_ok = 1'b1;
        got = 0;
        t = 0;
        while (got < 64 && t < 8000) begin
            if (!b_busy) busy_ok = 1'b0;
            if (b_out_valid) begin
                checks++;
                if (b_out_data !== rx[got]) begin
                    errors++;
                    $display("FAIL rt_y%0d: got %h want %h", got, b_out_data, rx[got]);
                end
                checks++;
                if (b_out_last !== (got == 63)) begin
                    errors++;
                    $display("FAIL rt_last%0d: got %0d want %0d", got, b_out_last, (got == 63));
                end
                got++;
            end
            @(negedge clk);
            t++;
        end
        checks++;
        if (got != 64) begin
            errors++;
            $display("FAIL rt_count: got %0d want 64", got);
        end
        checks++;
        if (!busy_ok) begin
            errors++;
            $display("FAIL rt_busy: got 0 want 1");
        end
        checks++;
        if (b_busy !== 1'b0 || b_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rt_end: busy=%0d rdy=%0d want 0 1", b_busy, b_in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_delta();
        test_vectors();
        test_unreduced_gaps();
        test_backpressure();
        test_abort();
        test_round_trip();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
